// File: rtl/barvinn_mvu_csr_bridge_if.sv
// CSR access port between the pito barrel core and the MVU CSR bridge.
// The core is the master; the bridge answers combinationally.
interface barvinn_mvu_csr_bridge_if #(
    parameter int unsigned N_HARTS = 8,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ADDR_W  = 12
);
    localparam int unsigned HW = (N_HARTS > 1) ? $clog2(N_HARTS) : 1;

    logic              csr_we;
    logic [HW-1:0]     csr_hart_id;
    logic [ADDR_W-1:0] csr_addr;
    logic [XLEN-1:0]   csr_wdata;
    logic [XLEN-1:0]   csr_rdata;
    logic              csr_hit;

    modport master (
        output csr_we, csr_hart_id, csr_addr, csr_wdata,
        input  csr_rdata, csr_hit
    );

    modport slave (
        input  csr_we, csr_hart_id, csr_addr, csr_wdata,
        output csr_rdata, csr_hit
    );
endinterface

// File: rtl/barvinn_mvu_csr_bridge.sv
// Per-hart custom CSR bank for the MVUs: config registers, job launch,
// busy tracking and a level interrupt on MVU completion.
module barvinn_mvu_csr_bridge #(
    parameter int unsigned N_HARTS = 8,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ADDR_W  = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    barvinn_mvu_csr_bridge_if.slave csr_bus,
    output logic [N_HARTS-1:0]     mvu_start,
    input  logic [N_HARTS-1:0]     mvu_done,
    output logic [N_HARTS*6-1:0]   mvu_wprec,
    output logic [N_HARTS*6-1:0]   mvu_iprec,
    output logic [N_HARTS*6-1:0]   mvu_oprec,
    output logic [N_HARTS*15-1:0]  mvu_wbase,
    output logic [N_HARTS*15-1:0]  mvu_ibase,
    output logic [N_HARTS*15-1:0]  mvu_obase,
    output logic [N_HARTS*15-1:0]  mvu_countdown,
    output logic [N_HARTS*2-1:0]   mvu_mul_mode,
    output logic [N_HARTS-1:0]     mvu_irq
);
    localparam int unsigned HW = (N_HARTS > 1) ? $clog2(N_HARTS) : 1;
    localparam logic [ADDR_W-1:0] CSR_BASE = 'h7C0;
    localparam logic [ADDR_W-1:0] CSR_LAST = 'h7C9;

    typedef enum logic [3:0] {
        CSR_WPREC   = 4'd0,
        CSR_IPREC   = 4'd1,
        CSR_OPREC   = 4'd2,
        CSR_WBASE   = 4'd3,
        CSR_IBASE   = 4'd4,
        CSR_OBASE   = 4'd5,
        CSR_CNTDN   = 4'd6,
        CSR_MULMODE = 4'd7,
        CSR_CMD     = 4'd8,
        CSR_STATUS  = 4'd9
    } csr_idx_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } hart_state_e;

    logic [5:0]  wprec_q [N_HARTS];
    logic [5:0]  iprec_q [N_HARTS];
    logic [5:0]  oprec_q [N_HARTS];
    logic [14:0] wbase_q [N_HARTS];
    logic [14:0] ibase_q [N_HARTS];
    logic [14:0] obase_q [N_HARTS];
    logic [14:0] cntdn_q [N_HARTS];
    logic [1:0]  mode_q  [N_HARTS];

    hart_state_e       state_q [N_HARTS];
    hart_state_e       state_d [N_HARTS];
    logic [N_HARTS-1:0] irq_q, irq_d, err_q, err_d, start_q, start_d, cfg_we;

    logic     hit;
    csr_idx_e idx;
    logic     unused_wdata;

    assign hit          = (csr_bus.csr_addr >= CSR_BASE) && (csr_bus.csr_addr <= CSR_LAST);
    assign idx          = csr_idx_e'(4'(csr_bus.csr_addr - CSR_BASE));
    assign unused_wdata = ^csr_bus.csr_wdata[XLEN-1:15];
    assign csr_bus.csr_hit = hit;

    // Done is applied after the CSR write so that a done coinciding with a
    // status clear leaves irq_pending set, and a coinciding command sees busy.
    always_comb begin
        for (int unsigned h = 0; h < N_HARTS; h++) begin
            state_d[h] = state_q[h];
            irq_d[h]   = irq_q[h];
            err_d[h]   = err_q[h];
            start_d[h] = 1'b0;
            cfg_we[h]  = 1'b0;
            if (csr_bus.csr_we && hit && (csr_bus.csr_hart_id == HW'(h))) begin
                case (idx)
                    CSR_CMD: begin
                        if (csr_bus.csr_wdata[0]) begin
                            if (state_q[h] == S_BUSY) begin
                                err_d[h] = 1'b1;
                            end else begin
                                start_d[h] = 1'b1;
                                state_d[h] = S_BUSY;
                            end
                        end
                    end
                    CSR_STATUS: begin
                        if (csr_bus.csr_wdata[1]) irq_d[h] = 1'b0;
                        if (csr_bus.csr_wdata[2]) err_d[h] = 1'b0;
                    end
                    default: begin
                        if (state_q[h] == S_BUSY) err_d[h]  = 1'b1;
                        else                      cfg_we[h] = 1'b1;
                    end
                endcase
            end
            if (mvu_done[h] && (state_q[h] == S_BUSY)) begin
                state_d[h] = S_IDLE;
                irq_d[h]   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned h = 0; h < N_HARTS; h++) state_q[h] <= S_IDLE;
            irq_q   <= '0;
            err_q   <= '0;
            start_q <= '0;
        end else begin
            for (int unsigned h = 0; h < N_HARTS; h++) state_q[h] <= state_d[h];
            irq_q   <= irq_d;
            err_q   <= err_d;
            start_q <= start_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned h = 0; h < N_HARTS; h++) begin
                wprec_q[h] <= '0;
                iprec_q[h] <= '0;
                oprec_q[h] <= '0;
                wbase_q[h] <= '0;
                ibase_q[h] <= '0;
                obase_q[h] <= '0;
                cntdn_q[h] <= '0;
                mode_q[h]  <= '0;
            end
        end else begin
            for (int unsigned h = 0; h < N_HARTS; h++) begin
                if (cfg_we[h]) begin
                    case (idx)
                        CSR_WPREC:   wprec_q[h] <= csr_bus.csr_wdata[5:0];
                        CSR_IPREC:   iprec_q[h] <= csr_bus.csr_wdata[5:0];
                        CSR_OPREC:   oprec_q[h] <= csr_bus.csr_wdata[5:0];
                        CSR_WBASE:   wbase_q[h] <= csr_bus.csr_wdata[14:0];
                        CSR_IBASE:   ibase_q[h] <= csr_bus.csr_wdata[14:0];
                        CSR_OBASE:   obase_q[h] <= csr_bus.csr_wdata[14:0];
                        CSR_CNTDN:   cntdn_q[h] <= csr_bus.csr_wdata[14:0];
                        CSR_MULMODE: mode_q[h]  <= csr_bus.csr_wdata[1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        csr_bus.csr_rdata = '0;
        if (hit) begin
            case (idx)
                CSR_WPREC:   csr_bus.csr_rdata = XLEN'(wprec_q[csr_bus.csr_hart_id]);
                CSR_IPREC:   csr_bus.csr_rdata = XLEN'(iprec_q[csr_bus.csr_hart_id]);
                CSR_OPREC:   csr_bus.csr_rdata = XLEN'(oprec_q[csr_bus.csr_hart_id]);
                CSR_WBASE:   csr_bus.csr_rdata = XLEN'(wbase_q[csr_bus.csr_hart_id]);
                CSR_IBASE:   csr_bus.csr_rdata = XLEN'(ibase_q[csr_bus.csr_hart_id]);
                CSR_OBASE:   csr_bus.csr_rdata = XLEN'(obase_q[csr_bus.csr_hart_id]);
                CSR_CNTDN:   csr_bus.csr_rdata = XLEN'(cntdn_q[csr_bus.csr_hart_id]);
                CSR_MULMODE: csr_bus.csr_rdata = XLEN'(mode_q[csr_bus.csr_hart_id]);
                CSR_STATUS:  csr_bus.csr_rdata = XLEN'({err_q[csr_bus.csr_hart_id],
                                                        irq_q[csr_bus.csr_hart_id],
                                                        state_q[csr_bus.csr_hart_id] == S_BUSY});
                default:     csr_bus.csr_rdata = '0;
            endcase
        end
    end

    always_comb begin
        for (int unsigned h = 0; h < N_HARTS; h++) begin
            mvu_wprec[6*h +: 6]      = wprec_q[h];
            mvu_iprec[6*h +: 6]      = iprec_q[h];
            mvu_oprec[6*h +: 6]      = oprec_q[h];
            mvu_wbase[15*h +: 15]    = wbase_q[h];
            mvu_ibase[15*h +: 15]    = ibase_q[h];
            mvu_obase[15*h +: 15]    = obase_q[h];
            mvu_countdown[15*h +: 15] = cntdn_q[h];
            mvu_mul_mode[2*h +: 2]   = mode_q[h];
        end
    end

    assign mvu_start = start_q;
    assign mvu_irq   = irq_q;
endmodule

// File: tb/tb_barvinn_mvu_csr_bridge.sv
// Directed bench for the MVU CSR bridge: CSR map, launch/done handshake,
// error flag, irq set/clear priority and asynchronous reset.
module tb_barvinn_mvu_csr_bridge;
    localparam int unsigned N_HARTS = 8;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned ADDR_W  = 12;

    localparam logic [11:0] A_WPREC = 12'h7C0, A_IPREC = 12'h7C1, A_OPREC = 12'h7C2,
                            A_WBASE = 12'h7C3, A_CNTDN = 12'h7C6, A_MODE  = 12'h7C7,
                            A_CMD   = 12'h7C8, A_STAT  = 12'h7C9;

    logic clk = 1'b0;
    logic rst_n;
    logic [N_HARTS-1:0]    mvu_start, mvu_done, mvu_irq;
    logic [N_HARTS*6-1:0]  mvu_wprec, mvu_iprec, mvu_oprec;
    logic [N_HARTS*15-1:0] mvu_wbase, mvu_ibase, mvu_obase, mvu_countdown;
    logic [N_HARTS*2-1:0]  mvu_mul_mode;

    int n_checks = 0;
    int n_pass   = 0;

    barvinn_mvu_csr_bridge_if #(.N_HARTS(N_HARTS), .XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

    barvinn_mvu_csr_bridge #(.N_HARTS(N_HARTS), .XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .csr_bus      (bus.slave),
        .mvu_start    (mvu_start),
        .mvu_done     (mvu_done),
        .mvu_wprec    (mvu_wprec),
        .mvu_iprec    (mvu_iprec),
        .mvu_oprec    (mvu_oprec),
        .mvu_wbase    (mvu_wbase),
        .mvu_ibase    (mvu_ibase),
        .mvu_obase    (mvu_obase),
        .mvu_countdown(mvu_countdown),
        .mvu_mul_mode (mvu_mul_mode),
        .mvu_irq      (mvu_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        else n_pass++;
    endtask

    // Drive one write; returns 1 time unit after the edge that commits it.
    task automatic csr_wr(input int h, input logic [11:0] a, input logic [31:0] d);
        bus.csr_we      = 1'b1;
        bus.csr_hart_id = 3'(h);
        bus.csr_addr    = a;
        bus.csr_wdata   = d;
        @(posedge clk);
        #1;
        bus.csr_we      = 1'b0;
        bus.csr_wdata   = '0;
    endtask

    task automatic rd_check(input string tag, input int h, input logic [11:0] a,
                            input logic [31:0] exp);
        bus.csr_we      = 1'b0;
        bus.csr_hart_id = 3'(h);
        bus.csr_addr    = a;
        #1;
        check(tag, bus.csr_rdata, exp);
    endtask

    task automatic pulse_done(input logic [7:0] m);
        mvu_done = m;
        @(posedge clk);
        #1;
        mvu_done = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n           = 1'b0;
        mvu_done        = '0;
        bus.csr_we      = 1'b0;
        bus.csr_hart_id = '0;
        bus.csr_addr    = '0;
        bus.csr_wdata   = '0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state: every mapped CSR reads 0 and hits; 0x7CA misses.
        for (int i = 0; i < 2; i++) begin
            for (int a = 0; a < 10; a++) begin
                rd_check($sformatf("rst_rd_h%0d_a%0d", i * 7, a), i * 7, 12'h7C0 + 12'(a), 32'h0);
                check($sformatf("rst_hit_h%0d_a%0d", i * 7, a), 32'(bus.csr_hit), 32'h1);
            end
        end
        rd_check("unmapped_rd", 0, 12'h7CA, 32'h0);
        check("unmapped_hit", 32'(bus.csr_hit), 32'h0);
        bus.csr_addr = 12'h7BF;
        #1 check("below_map_hit", 32'(bus.csr_hit), 32'h0);
        check("rst_start", 32'(mvu_start), 32'h0);
        check("rst_irq", 32'(mvu_irq), 32'h0);

        // Hart 3 configuration lands in its packed slice only.
        csr_wr(3, A_WPREC, 32'd2);
        csr_wr(3, A_IPREC, 32'd2);
        csr_wr(3, A_OPREC, 32'd32);
        csr_wr(3, A_CNTDN, 32'hFFFF_FFFF);
        csr_wr(3, A_MODE,  32'd3);
        check("h3_wprec", 32'(mvu_wprec[23:18]), 32'd2);
        check("h3_iprec", 32'(mvu_iprec[23:18]), 32'd2);
        check("h3_oprec", 32'(mvu_oprec[23:18]), 32'd32);
        check("h3_cntdn", 32'(mvu_countdown[59:45]), 32'h7FFF);
        check("h3_mode",  32'(mvu_mul_mode[7:6]), 32'd3);
        check("wprec_others", 32'(|{mvu_wprec[47:24], mvu_wprec[17:0]}), 32'h0);
        check("cntdn_others", 32'(|{mvu_countdown[119:60], mvu_countdown[44:0]}), 32'h0);
        check("mode_others",  32'(|{mvu_mul_mode[15:8], mvu_mul_mode[5:0]}), 32'h0);
        rd_check("h3_cntdn_rd", 3, A_CNTDN, 32'h7FFF);
        rd_check("h2_wprec_rd", 2, A_WPREC, 32'h0);

        // Command with bit0 clear does nothing.
        csr_wr(6, A_CMD, 32'hFFFF_FFFE);
        check("cmd0_start", 32'(mvu_start), 32'h0);
        rd_check("cmd0_status", 6, A_STAT, 32'h0);
        rd_check("cmd_reads0", 6, A_CMD, 32'h0);

        // Hart 1 launch, busy-time violations, done and irq clear.
        csr_wr(1, A_CMD, 32'h1);
        check("h1_start", 32'(mvu_start), 32'h02);
        rd_check("h1_busy", 1, A_STAT, 32'h1);
        csr_wr(1, A_CMD, 32'h1);
        check("h1_start_once", 32'(mvu_start), 32'h00);
        csr_wr(1, A_WBASE, 32'd5);
        rd_check("h1_wbase_kept", 1, A_WBASE, 32'h0);
        check("h1_wbase_out", 32'(mvu_wbase[29:15]), 32'h0);
        rd_check("h1_err", 1, A_STAT, 32'h5);
        csr_wr(1, A_STAT, 32'h4);
        rd_check("h1_err_clr", 1, A_STAT, 32'h1);
        pulse_done(8'h02);
        rd_check("h1_done_stat", 1, A_STAT, 32'h2);
        check("h1_irq", 32'(mvu_irq), 32'h02);
        pulse_done(8'h02);
        rd_check("h1_stray_done", 1, A_STAT, 32'h2);
        csr_wr(1, A_STAT, 32'h2);
        check("h1_irq_clr", 32'(mvu_irq), 32'h00);
        csr_wr(1, A_WBASE, 32'd5);
        check("h1_wbase_idle", 32'(mvu_wbase[29:15]), 32'd5);

        // Coincident done pulses on harts 0 and 5.
        csr_wr(0, A_CMD, 32'h1);
        csr_wr(5, A_CMD, 32'h1);
        check("h5_start", 32'(mvu_start), 32'h20);
        pulse_done(8'h21);
        check("dual_irq", 32'(mvu_irq), 32'h21);

        // Done and irq clear in the same cycle: set wins.
        csr_wr(0, A_CMD, 32'h1);
        mvu_done = 8'h01;
        csr_wr(0, A_STAT, 32'h2);
        mvu_done = '0;
        check("set_wins_irq", 32'(mvu_irq), 32'h21);
        rd_check("set_wins_stat", 0, A_STAT, 32'h2);

        // Back-to-back: done at edge M, command at edge M+1 accepted.
        csr_wr(5, A_CMD, 32'h1);
        pulse_done(8'h20);
        csr_wr(5, A_CMD, 32'h1);
        check("b2b_start", 32'(mvu_start), 32'h20);
        rd_check("b2b_stat", 5, A_STAT, 32'h3);

        // Command and done together: done processed, command rejected.
        mvu_done = 8'h20;
        csr_wr(5, A_CMD, 32'h1);
        mvu_done = '0;
        check("cmd_done_start", 32'(mvu_start), 32'h00);
        rd_check("cmd_done_stat", 5, A_STAT, 32'h6);

        // Asynchronous reset mid-cycle with a job and a pending irq.
        csr_wr(0, A_STAT, 32'h6);
        csr_wr(5, A_STAT, 32'h6);
        csr_wr(4, A_CMD, 32'h1);
        pulse_done(8'h10);
        check("h4_irq", 32'(mvu_irq), 32'h10);
        csr_wr(2, A_CMD, 32'h1);
        check("h2_start", 32'(mvu_start), 32'h04);
        #2 rst_n = 1'b0;
        #1;
        check("arst_start", 32'(mvu_start), 32'h0);
        check("arst_irq", 32'(mvu_irq), 32'h0);
        check("arst_wprec", 32'(|mvu_wprec), 32'h0);
        check("arst_cntdn", 32'(|mvu_countdown), 32'h0);
        rd_check("arst_h2_stat", 2, A_STAT, 32'h0);
        @(posedge clk);
        #1;
        check("rst_hold_irq", 32'(mvu_irq), 32'h0);
        #3 rst_n = 1'b1;
        csr_wr(2, A_CMD, 32'h1);
        check("post_rst_start", 32'(mvu_start), 32'h04);
        rd_check("post_rst_busy", 2, A_STAT, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/barvinn_mvu_csr_bridge.md
Name: barvinn_mvu_csr_bridge

Overview:
- Glue block inside the barvinn top, between the pito RISC-V barrel core's CSR port and the 8 MVU (matrix-vector unit) instances.
- Each pito hart owns one MVU and programs it through a per-hart bank of custom CSRs.
- A command write launches the job: the block issues a one-cycle start pulse and tracks busy.
- On the MVU's done pulse it raises a level interrupt to the owning hart.

Parameters:
- N_HARTS, 8, number of harts/MVUs; hart index width HW = clog2(N_HARTS).
- XLEN, 32, CSR data width.
- ADDR_W, 12, CSR address width.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- csr_we  in  1  CSR write strobe, one cycle per write.
- csr_hart_id  in  HW  hart issuing the CSR access.
- csr_addr  in  ADDR_W  CSR address.
- csr_wdata  in  XLEN  write data.
- csr_rdata  out  XLEN  combinational read data for (csr_hart_id, csr_addr).
- csr_hit  out  1  high when csr_addr is in the bridge map.
- mvu_start  out  N_HARTS  one-cycle start pulse per MVU.
- mvu_done  in  N_HARTS  one-cycle done pulse per MVU.
- mvu_wprec, mvu_iprec, mvu_oprec  out  N_HARTS*6 each  packed precision fields; hart h occupies bits [6h+5:6h].
- mvu_wbase, mvu_ibase, mvu_obase, mvu_countdown  out  N_HARTS*15 each  packed, hart h at [15h+14:15h].
- mvu_mul_mode  out  N_HARTS*2  packed, hart h at [2h+1:2h].
- mvu_irq  out  N_HARTS  level interrupt per hart.

Behaviour:
- Reset: all config registers, busy, irq_pending, err and mvu_start go to 0 immediately on rst_n low. Outputs stay 0 until rst_n returns high.
- CSR map (per hart; writes use the low bits of csr_wdata, reads are zero-extended):
  - 0x7C0 wprec[5:0]
  - 0x7C1 iprec[5:0]
  - 0x7C2 oprec[5:0]
  - 0x7C3 wbase[14:0]
  - 0x7C4 ibase[14:0]
  - 0x7C5 obase[14:0]
  - 0x7C6 countdown[14:0]
  - 0x7C7 mul_mode[1:0]
  - 0x7C8 command: write-only, reads 0
  - 0x7C9 status: bit0 busy, bit1 irq_pending, bit2 err; all other bits 0
- Unmapped address: csr_rdata = 0, csr_hit = 0, writes ignored. csr_hit is independent of csr_we.
- Config writes take effect on the next edge, and only when that hart is not busy.
  - A config write while busy is dropped and sets err.
  - Config outputs are driven directly from the registers, so they are stable for the whole job.
- Command write with wdata[0]=1 while idle, at edge N:
  - mvu_start[h] is high for exactly cycle N+1.
  - busy = 1 from N+1.
  - wdata[0]=0: no effect.
  - Command while busy: ignored, sets err.
- mvu_done[h] while busy at edge M: busy = 0 and irq_pending = 1 from M+1. mvu_done while not busy is ignored.
- mvu_irq[h] = irq_pending[h], level.
- Status write:
  - wdata[1]=1 clears irq_pending.
  - wdata[2]=1 clears err.
  - Other bits ignored.
  - If done and a clear arrive in the same cycle, the set wins.
- Same hart, command and done in the same cycle: the done is processed, the command counts as busy (ignored, err=1).
- Harts are fully independent. CSR access is one hart per cycle, while done pulses on different harts may coincide and are all honoured.
- Back-to-back: a command written in the cycle after busy clears is accepted.

Test Plan:
- Reset, then read all ten CSRs for harts 0 and 7 -> every read returns 0, csr_hit=1; read 0x7CA -> csr_hit=0, rdata=0.
- Hart 3 writes wprec=2, iprec=2, oprec=32, countdown=0x7FFF, mul_mode=3 -> mvu_wprec[23:18]=2, mvu_oprec[23:18]=32, mvu_countdown[59:45]=0x7FFF, mvu_mul_mode[7:6]=3; other harts' fields stay 0.
- Hart 1 writes command=1 at edge N -> mvu_start=8'h02 for exactly one cycle; status reads busy=1. Pulse mvu_done[1] -> next cycle status=0x2 and mvu_irq[1]=1. Write status 0x2 -> irq drops.
- While hart 1 is busy: write command and wbase=5 -> no second start pulse, wbase unchanged, status bit2=1; writing status 0x4 clears it.
- Harts 0 and 5 both busy, mvu_done=8'h21 in one cycle -> both irqs rise together. Clear hart 0's irq in the same cycle a new done arrives -> irq stays 1.
- Assert rst_n low while hart 2 is busy with irq pending on hart 4 -> all outputs 0 immediately; after release, a new command starts normally.
